// File: rtl/watch_pkg.sv
// Shared definitions for the watch setting path: modes, BCD digit fields and keypad decode.
package watch_pkg;

  // Controller modes; the encoding is visible on the mode output.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SET_TIME  = 2'd1,
    SET_ALARM = 2'd2,
    COMMIT    = 2'd3
  } mode_e;

  // BCD digit fields inside the 24-bit {h_ten,h_one,m_ten,m_one,s_ten,s_one} word.
  localparam int DIGIT_W   = 4;
  localparam int H_TEN_LSB = 20;
  localparam int H_ONE_LSB = 16;
  localparam int M_TEN_LSB = 12;
  localparam int M_ONE_LSB = 8;
  localparam int S_TEN_LSB = 4;
  localparam int S_ONE_LSB = 0;

  // Cursor position of the final digit of each entry sequence.
  localparam logic [2:0] TIME_LAST_CURSOR  = 3'd5;
  localparam logic [2:0] ALARM_LAST_CURSOR = 3'd3;

  // True when exactly one key line is active.
  function automatic logic is_one_hot(input logic [9:0] keys);
    return (keys != 10'd0) && ((keys & (keys - 10'd1)) == 10'd0);
  endfunction

  // Index of the active key line; only meaningful for one-hot input.
  function automatic logic [3:0] onehot_to_bcd(input logic [9:0] keys);
    logic [3:0] digit;
    digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (keys[i]) digit = 4'(i);
    end
    return digit;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Keypad sampler: turns a fresh one-hot press into a single-cycle strobe with its digit.
module key_edge
  import watch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] keypad,
  output logic       valid,
  output logic [3:0] digit
);

  logic [9:0] cur_q;
  logic [9:0] prev_q;

  // Two-deep sample history; a press counts only after an all-released sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q  <= '0;
      prev_q <= '0;
    end else begin
      cur_q  <= keypad;
      prev_q <= cur_q;
    end
  end

  assign valid = is_one_hot(cur_q) && (prev_q == 10'd0);
  assign digit = onehot_to_bcd(cur_q);

endmodule

// File: rtl/watch_set_ctrl.sv
// Keypad-driven time/alarm setting controller with range checking, timeout and cursor blink.
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int CLK_HZ      = 1000,
  parameter int TIMEOUT_CYC = 10 * CLK_HZ,
  parameter int BLINK_HALF  = CLK_HZ / 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_key,
  input  logic [9:0]  keypad,
  input  logic [23:0] time_bcd,
  input  logic [15:0] alarm_bcd,
  output logic [23:0] new_bcd,
  output logic        load_time,
  output logic        load_alarm,
  output logic        run_en,
  output logic [23:0] disp_bcd,
  output logic [5:0]  disp_blank,
  output logic [1:0]  mode
);

  localparam int IDLE_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int BLINK_W = $clog2(BLINK_HALF + 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic               key_valid;
  logic [3:0]         key_digit;
  logic               mode_key_q;
  logic               mode_key_prev_q;
  logic               mode_edge;

  mode_e              state_q;
  mode_e              state_d;
  logic [2:0]         cursor_q;
  logic [2:0]         cursor_d;
  logic [23:0]        buf_q;
  logic [23:0]        buf_d;
  logic               alarm_origin_q;
  logic               alarm_origin_d;

  logic [IDLE_W-1:0]  idle_q;
  logic               in_set;
  logic               timeout;
  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_phase_q;

  logic               key_in_range;
  logic [23:0]        written_bcd;
  logic [2:0]         last_cursor;

  key_edge u_key_edge (
    .clk    (clk),
    .rst    (rst),
    .keypad (keypad),
    .valid  (key_valid),
    .digit  (key_digit)
  );

  // Mode button is sampled the same way as the keypad so both events line up in time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_key_q      <= 1'b0;
      mode_key_prev_q <= 1'b0;
    end else begin
      mode_key_q      <= mode_key;
      mode_key_prev_q <= mode_key_q;
    end
  end

  assign mode_edge   = mode_key_q & ~mode_key_prev_q;
  assign in_set      = (state_q == SET_TIME) || (state_q == SET_ALARM);
  assign timeout     = in_set && !key_valid && !mode_edge && (idle_q == IDLE_LAST);
  assign last_cursor = (state_q == SET_TIME) ? TIME_LAST_CURSOR : ALARM_LAST_CURSOR;

  // Idle counter restarts on any user activity and only runs while a set mode is open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
    end else if (!in_set || key_valid || mode_edge || timeout) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + IDLE_W'(1);
    end
  end

  // Free-running blink phase, forced back to the visible phase on every key press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (key_valid) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + BLINK_W'(1);
    end
  end

  // Range check of the pressed digit against the cursor field, plus the buffer it would produce.
  always_comb begin
    key_in_range = 1'b0;
    written_bcd  = buf_q;
    unique case (cursor_q)
      3'd0: begin
        key_in_range = (key_digit <= 4'd2);
        written_bcd[H_TEN_LSB +: DIGIT_W] = key_digit;
        if ((key_digit == 4'd2) && (buf_q[H_ONE_LSB +: DIGIT_W] > 4'd3)) begin
          written_bcd[H_ONE_LSB +: DIGIT_W] = 4'd0;
        end
      end
      3'd1: begin
        if (buf_q[H_TEN_LSB +: DIGIT_W] == 4'd2) begin
          key_in_range = (key_digit <= 4'd3);
        end else begin
          key_in_range = (key_digit <= 4'd9);
        end
        written_bcd[H_ONE_LSB +: DIGIT_W] = key_digit;
      end
      3'd2: begin
        key_in_range = (key_digit <= 4'd5);
        written_bcd[M_TEN_LSB +: DIGIT_W] = key_digit;
      end
      3'd3: begin
        key_in_range = (key_digit <= 4'd9);
        written_bcd[M_ONE_LSB +: DIGIT_W] = key_digit;
      end
      3'd4: begin
        key_in_range = (key_digit <= 4'd5);
        written_bcd[S_TEN_LSB +: DIGIT_W] = key_digit;
      end
      3'd5: begin
        key_in_range = (key_digit <= 4'd9);
        written_bcd[S_ONE_LSB +: DIGIT_W] = key_digit;
      end
      default: key_in_range = 1'b0;
    endcase
  end

  // FSM state, cursor, entry buffer and commit target registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      cursor_q       <= 3'd0;
      buf_q          <= '0;
      alarm_origin_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cursor_q       <= cursor_d;
      buf_q          <= buf_d;
      alarm_origin_q <= alarm_origin_d;
    end
  end

  // Next-state logic: mode edges win over keys, timeouts abort, the last digit commits.
  always_comb begin
    state_d        = state_q;
    cursor_d       = cursor_q;
    buf_d          = buf_q;
    alarm_origin_d = alarm_origin_q;
    unique case (state_q)
      RUN: begin
        if (mode_edge) begin
          state_d        = SET_TIME;
          cursor_d       = 3'd0;
          buf_d          = time_bcd;
          alarm_origin_d = 1'b0;
        end
      end
      SET_TIME, SET_ALARM: begin
        if (mode_edge) begin
          cursor_d = 3'd0;
          if (state_q == SET_TIME) begin
            state_d        = SET_ALARM;
            buf_d          = {alarm_bcd, 8'h00};
            alarm_origin_d = 1'b1;
          end else begin
            state_d = RUN;
            buf_d   = '0;
          end
        end else if (timeout) begin
          state_d  = RUN;
          cursor_d = 3'd0;
          buf_d    = '0;
        end else if (key_valid && key_in_range) begin
          buf_d = written_bcd;
          if (cursor_q == last_cursor) begin
            state_d  = COMMIT;
            cursor_d = 3'd0;
          end else begin
            cursor_d = cursor_q + 3'd1;
          end
        end
      end
      COMMIT: begin
        state_d  = RUN;
        cursor_d = 3'd0;
      end
      default: state_d = RUN;
    endcase
  end

  // Display selection and per-digit blanking for the 7-segment scanner.
  always_comb begin
    disp_bcd   = time_bcd;
    disp_blank = 6'b000000;
    unique case (state_q)
      RUN: begin
        disp_bcd = time_bcd;
      end
      SET_TIME: begin
        disp_bcd = buf_q;
        disp_blank[3'd5 - cursor_q] = blink_phase_q;
      end
      SET_ALARM: begin
        disp_bcd = {buf_q[23:8], 8'h00};
        disp_blank[3'd5 - cursor_q] = blink_phase_q;
        disp_blank[1:0] = 2'b11;
      end
      COMMIT: begin
        if (alarm_origin_q) begin
          disp_bcd        = {buf_q[23:8], 8'h00};
          disp_blank[1:0] = 2'b11;
        end else begin
          disp_bcd = buf_q;
        end
      end
      default: disp_bcd = time_bcd;
    endcase
  end

  assign new_bcd    = buf_q;
  assign mode       = state_q;
  assign load_time  = (state_q == COMMIT) && !alarm_origin_q;
  assign load_alarm = (state_q == COMMIT) && alarm_origin_q;
  assign run_en     = !((state_q == SET_TIME) || ((state_q == COMMIT) && !alarm_origin_q));

endmodule
